// File: rtl/common_params.sv
// Shared definitions for the instruction fetch path.
//   BITS          : data/address width used throughout fetch
//   NOP, ECALL_i  : full instruction encodings
//   JAL_i         : JAL major opcode (inst[6:0])
//   fetch_entry_t : one prefetch queue entry
//   j_imm()       : sign-extended J-type immediate
package common_params;

  localparam int BITS = 32;

  localparam logic [BITS-1:0] NOP     = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [BITS-1:0] ECALL_i = 32'h0000_0073;
  localparam logic [6:0]      JAL_i   = 7'b110_1111;

  typedef struct packed {
    logic [BITS-1:0] inst;
    logic [BITS-1:0] pc;
    logic [BITS-1:0] pc_inc;
    logic            hlt;
    logic            pred;
  } fetch_entry_t;

  function automatic logic [BITS-1:0] j_imm(input logic [BITS-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Push/pop/status bundle between the fetch control logic and its queue.
//   master : fetch control (push, push_data, pop, flush out; status in)
//   slave  : queue storage (status and head entry out)
interface fetch_prefetch_queue_if
  import common_params::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  fetch_entry_t  push_data;
  logic          pop;
  logic          flush;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  fetch_entry_t  head;

  modport master (output push, push_data, pop, flush,
                  input  full, empty, count, head);
  modport slave  (input  push, push_data, pop, flush,
                  output full, empty, count, head);
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries, DEPTH a power of two.
//   clk, rst_n : clock, asynchronous active-low reset
//   q (slave)  : push/pop/flush in; full/empty/count/head out
// The head entry is read combinationally, so a push at edge N is visible
// right after edge N. Flush empties the queue and wins over push/pop.
module fetch_fifo
  import common_params::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fetch_prefetch_queue_if.slave        q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en, rd_en;

  // A pop frees the slot a simultaneous push needs, so push is legal when full.
  assign wr_en = q.push && !q.flush && (!q.full || q.pop);
  assign rd_en = q.pop && !q.flush && !q.empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (q.flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) wp_d = wp_q + AW'(1);
      if (rd_en) rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= q.push_data;
  end

  assign q.head  = mem_q[rp_q];
  assign q.count = cnt_q;
  assign q.empty = (cnt_q == '0);
  assign q.full  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch: issues sequential fetches to a gnt/rvalid memory,
// buffers responses in a DEPTH-entry queue and presents the head to decode.
//   clk, rst_n          : clock, asynchronous active-low reset
//   PC_SRC, TARGET_ADDR : redirect from execute (flush + refetch)
//   STALL               : decode holds the current head
//   imem_*              : request/grant and in-order response channel
//   IF_ID_*             : head entry towards decode
// Optional: FETCH_JAL_PREDICT_EN redirects fetch at JAL words as they arrive.
module fetch_prefetch_queue
  import common_params::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_SRC,
  input  logic [BITS-1:0] TARGET_ADDR,
  input  logic            STALL,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [BITS-1:0] imem_rdata,
  output logic            IF_ID_VALID,
  output logic [BITS-1:0] IF_ID_Inst,
  output logic [BITS-1:0] IF_ID_PC,
  output logic [BITS-1:0] IF_ID_PC_INC,
  output logic            IF_ID_HLT,
  output logic            IF_ID_PRED
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic            run_q, run_d;        // holds requests off for the first cycle after reset
  logic [BITS-1:0] pc_q, pc_d;          // next address to request
  logic [BITS-1:0] rsp_pc_q, rsp_pc_d;  // PC of the next current-epoch response
  logic            epoch_q, epoch_d;
  logic            halted_q, halted_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [DEPTH-1:0] tag_q, tag_d;       // epoch of each in-flight request
  logic [AW-1:0]   tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [BITS-1:0] last_pc_q, last_pc_d, last_inc_q, last_inc_d;

  logic            rsp_valid, rsp_keep, req_acc, jal_hit, credit_ok;
  logic [BITS-1:0] jal_target;
  logic [CW:0]     inflight;
  fetch_entry_t    entry;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (fq.slave)
  );

  // Queued plus in-flight never exceeds DEPTH, so a response always has room.
  assign inflight  = {1'b0, fq.count} + {1'b0, out_cnt_q};
  assign credit_ok = inflight < DEPTH_W;

  // With nothing outstanding (e.g. just after reset) a response is stray.
  assign rsp_valid = imem_rvalid && (out_cnt_q != '0);
  assign rsp_keep  = rsp_valid && (tag_q[tag_rp_q] == epoch_q) && !PC_SRC;

`ifdef FETCH_JAL_PREDICT_EN
  assign jal_hit    = rsp_keep && (imem_rdata[6:0] == JAL_i);
  assign jal_target = rsp_pc_q + j_imm(imem_rdata);
`else
  assign jal_hit    = 1'b0;
  assign jal_target = rsp_pc_q;
`endif

  // A predicted JAL retargets pc_q this cycle, so no request goes out with it.
  assign imem_req  = run_q && !halted_q && !PC_SRC && !jal_hit && credit_ok;
  assign imem_addr = pc_q;
  assign req_acc   = imem_req && imem_gnt;

  always_comb begin
    entry        = '0;
    entry.inst   = imem_rdata;
    entry.pc     = rsp_pc_q;
    entry.pc_inc = rsp_pc_q + 32'd4;
    entry.hlt    = (imem_rdata == ECALL_i);
    entry.pred   = jal_hit;
  end

  assign fq.push      = rsp_keep;
  assign fq.push_data = entry;
  assign fq.pop       = !fq.empty && !STALL && !PC_SRC;
  assign fq.flush     = PC_SRC;

  always_comb begin
    run_d      = 1'b1;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    epoch_d    = epoch_q;
    halted_d   = halted_q;
    out_cnt_d  = out_cnt_q + CW'(req_acc) - CW'(rsp_valid);
    tag_d      = tag_q;
    tag_wp_d   = tag_wp_q;
    tag_rp_d   = tag_rp_q;
    last_pc_d  = last_pc_q;
    last_inc_d = last_inc_q;

    if (req_acc) begin
      tag_d[tag_wp_q] = epoch_q;
      tag_wp_d        = tag_wp_q + AW'(1);
    end
    if (rsp_valid) tag_rp_d = tag_rp_q + AW'(1);

    // PC fields keep showing the last head once the queue runs dry.
    if (!fq.empty) begin
      last_pc_d  = fq.head.pc;
      last_inc_d = fq.head.pc_inc;
    end

    if (PC_SRC) begin
      pc_d     = TARGET_ADDR;
      rsp_pc_d = TARGET_ADDR;
      epoch_d  = ~epoch_q;
      halted_d = 1'b0;
    end else begin
      if (req_acc) pc_d = pc_q + 32'd4;
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        if (entry.hlt) halted_d = 1'b1;
      end
      if (jal_hit) begin
        pc_d     = jal_target;
        rsp_pc_d = jal_target;
        epoch_d  = ~epoch_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      epoch_q    <= 1'b0;
      halted_q   <= 1'b0;
      out_cnt_q  <= '0;
      tag_q      <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      last_pc_q  <= '0;
      last_inc_q <= 32'd4;
    end else begin
      run_q      <= run_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      epoch_q    <= epoch_d;
      halted_q   <= halted_d;
      out_cnt_q  <= out_cnt_d;
      tag_q      <= tag_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
      last_pc_q  <= last_pc_d;
      last_inc_q <= last_inc_d;
    end
  end

  assign IF_ID_VALID  = !fq.empty;
  assign IF_ID_Inst   = fq.empty ? NOP : fq.head.inst;
  assign IF_ID_PC     = fq.empty ? last_pc_q : fq.head.pc;
  assign IF_ID_PC_INC = fq.empty ? last_inc_q : fq.head.pc_inc;
  assign IF_ID_HLT    = !fq.empty && fq.head.hlt;
  assign IF_ID_PRED   = !fq.empty && fq.head.pred;

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: fetch address after reset.
REQ-003 SHALL use BITS (32) from common_params for all data and address widths.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- PC_SRC  in  1  redirect request from execute.
- TARGET_ADDR  in  BITS  redirect target.
- STALL  in  1  decode cannot accept; hold output.
- imem_req  out  1  fetch request valid.
- imem_addr  out  BITS  byte address of request.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  BITS  instruction word.
- IF_ID_VALID  out  1  head entry valid.
- IF_ID_Inst  out  BITS  head instruction.
- IF_ID_PC  out  BITS  head PC.
- IF_ID_PC_INC  out  BITS  head PC + 4.
- IF_ID_HLT  out  1  head opcode is ECALL.
- IF_ID_PRED  out  1  head was JAL-predicted (0 when macro absent).

Function
REQ-005 SHALL issue a request (imem_req=1, imem_addr=fetch PC) when not halted, PC_SRC=0, and occupancy + outstanding < DEPTH.
REQ-006 SHALL treat a request as accepted only when imem_req & imem_gnt; fetch PC then advances by 4 (mod 2^BITS) next cycle.
REQ-007 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-008 SHALL track up to DEPTH outstanding requests; responses return in order, one per imem_rvalid.
REQ-009 SHALL tag each request with a 1-bit epoch; a response whose epoch differs from current epoch SHALL be discarded and only decrement outstanding.
REQ-010 SHALL write each accepted response into the queue as {inst, pc, pc+4, hlt, pred}.
REQ-011 SHALL drive IF_ID_* from the queue head; IF_ID_VALID=1 iff queue non-empty.
REQ-012 SHALL drive IF_ID_Inst=NOP, IF_ID_HLT=0, IF_ID_PRED=0 when queue empty; PC fields then hold last values.
REQ-013 SHALL pop the head when IF_ID_VALID & ~STALL; push and pop in the same cycle SHALL leave occupancy unchanged, including when full.
REQ-014 SHALL never push when full (guaranteed by REQ-005 credit rule); read/write pointers wrap modulo DEPTH.
REQ-015 On PC_SRC=1 SHALL, next cycle: empty queue, fetch PC := TARGET_ADDR, toggle epoch, clear halted; no request issued in the PC_SRC cycle.
REQ-016 PC_SRC SHALL take priority over STALL, push, pop and halt in the same cycle.
REQ-017 SHALL set halted when a pushed word has opcode ECALL_i; once halted, no new requests; queued entries still drain.
REQ-018 Queue-to-output latency SHALL be one cycle: response pushed at edge N is visible on IF_ID_* after edge N.

Reset
REQ-019 On rst_n=0 (asynchronous) SHALL set: fetch PC=RESET_PC, queue empty, outstanding=0, epoch=0, halted=0, imem_req=0, IF_ID_VALID=0, IF_ID_Inst=NOP, IF_ID_PC=0, IF_ID_PC_INC=4, IF_ID_HLT=0, IF_ID_PRED=0.
REQ-020 Responses arriving during or after reset for pre-reset requests SHALL be ignored (outstanding=0 discards them).

Configuration
REQ-021 With FETCH_JAL_PREDICT_EN defined: when a pushed word is JAL with current epoch, fetch PC := its pc + sign-extended J-immediate, epoch toggles, younger in-flight responses discarded, entry marked pred=1.
REQ-022 Without FETCH_JAL_PREDICT_EN: fetch is strictly sequential and IF_ID_PRED is tied 0.

Structure
REQ-023 SHALL place NOP, ECALL_i, JAL_i and a fetch_entry_t struct {inst, pc, pc_inc, hlt, pred} in common_params.
REQ-024 SHALL implement storage as sub-module fetch_fifo (DEPTH-parametrised circular buffer with full/empty/count); request/epoch/PC control in top module.

Verification
REQ-025 Reset, 1-cycle-latency memory, STALL=0: PCs 0,4,8,... appear on consecutive cycles, IF_ID_PC_INC=PC+4.
REQ-026 DEPTH=4, STALL=1 held: exactly 4 entries fill, imem_req deasserts; STALL release drains 0,4,8,12 then resumes at 16.
REQ-027 PC_SRC=1 with TARGET_ADDR=0x100 and 3 in flight: stale responses dropped, next IF_ID_VALID entry has PC 0x100.
REQ-028 ECALL at 0x8: IF_ID_HLT=1 for PC 0x8, no request beyond 0xC issued after halt; subsequent PC_SRC to 0x40 resumes fetch.
REQ-029 imem_gnt low 5 cycles: imem_addr stable at 0x10 throughout; asserting rst_n=0 mid-stall forces REQ-019 values immediately.
REQ-030 FETCH_JAL_PREDICT_EN, JAL +0x20 at 0x4: next valid PC 0x24, IF_ID_PRED=1 on the JAL entry, entry for 0x8 never valid.
